// File: rtl/namuru_dump_collector.sv
// namuru_dump_collector: Wishbone master that drains correlator dumps into a record FIFO.
// Optional ack watchdog is enabled by defining NAMURU_DC_TIMEOUT_EN.
module namuru_dump_collector #(
    parameter int DEPTH   = 32,
    parameter int AW      = 5,
    parameter int TIMEOUT = 15
) (
    input  logic          correlator_clk,
    input  logic          correlator_rst,
    input  logic          accum_int,
    output logic [31:0]   m_adr_o,
    output logic [31:0]   m_dat_o,
    input  logic [31:0]   m_dat_i,
    output logic          m_we_o,
    output logic [3:0]    m_sel_o,
    output logic          m_cyc_o,
    output logic          m_stb_o,
    input  logic          m_ack_i,
    input  logic          rd_en,
    output logic [31:0]   rd_data,
    output logic          rd_empty,
    output logic [AW:0]   rd_level,
    output logic          overflow,
    input  logic          ovf_clr,
    output logic          irq,
    output logic          busy
);
    typedef enum logic [2:0] {IDLE, RD_STAT, RD_ND, HDR, RD_ACC, WR_CLR} state_t;

    state_t      state_q, state_d;
    logic [2:0]  idx_q, idx_d;
    logic        cyc_q, cyc_d, we_q, we_d;
    logic [31:0] adr_q, adr_d, dat_q, dat_d;
    logic [1:0]  stat_q, stat_d;
    logic        nd_q, nd_d;
    logic [15:0] seq_q, seq_d;
    logic        acc_q, pend_q, pend_d, ovf_q, ovf_d;
    logic [AW:0] wptr_q, wptr_d, rptr_q, rptr_d, level;
    logic [31:0] mem [DEPTH];
    logic        trig, ack, bus_st, push, pop, ovf_set;
    logic [31:0] push_data;
    logic        unused_hi;

`ifdef NAMURU_DC_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] tmo_q, tmo_d;
    logic [AW:0]   wsave_q, wsave_d;
`endif

    assign unused_hi = ^m_dat_i[31:16];
    assign trig      = accum_int & ~acc_q;
    assign ack       = cyc_q & m_ack_i;
    assign level     = wptr_q - rptr_q;
    assign pop       = rd_en & (level != '0);
    assign bus_st    = (state_q == RD_STAT) || (state_q == RD_ND) ||
                       (state_q == RD_ACC) || (state_q == WR_CLR);

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        cyc_d     = cyc_q;
        we_d      = we_q;
        adr_d     = adr_q;
        dat_d     = dat_q;
        stat_d    = stat_q;
        nd_d      = nd_q;
        seq_d     = seq_q;
        pend_d    = pend_q | (trig & (state_q != IDLE));
        ovf_set   = 1'b0;
        push      = 1'b0;
        push_data = '0;
`ifdef NAMURU_DC_TIMEOUT_EN
        wsave_d   = wsave_q;
        tmo_d     = cyc_q ? tmo_q + 1'b1 : '0;
`endif
        unique case (state_q)
            IDLE: begin
                if (trig || pend_q) begin
                    state_d = RD_STAT;
                    pend_d  = 1'b0;
                end
            end
            RD_STAT: begin
                if (ack) begin
                    stat_d  = m_dat_i[1:0];
                    state_d = RD_ND;
                end
            end
            RD_ND: begin
                if (ack) begin
                    nd_d    = m_dat_i[0];
                    state_d = HDR;
                end
            end
            HDR: begin
`ifdef NAMURU_DC_TIMEOUT_EN
                wsave_d = wptr_q;
`endif
                if (nd_q && level <= (AW+1)'(DEPTH - 7)) begin
                    push      = 1'b1;
                    push_data = {8'hA5, seq_q, 5'd0, nd_q, stat_q};
                    idx_d     = '0;
                    state_d   = RD_ACC;
                end else begin
                    ovf_set = nd_q;
                    state_d = WR_CLR;
                end
            end
            RD_ACC: begin
                if (ack) begin
                    push      = 1'b1;
                    push_data = {16'd0, m_dat_i[15:0]};
                    if (idx_q == 3'd5) begin
                        seq_d   = seq_q + 16'd1;
                        state_d = WR_CLR;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
            end
            WR_CLR: begin
                if (ack) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Each bus state launches its transfer one cycle after entry or after the previous ack.
        if (bus_st && !cyc_q) begin
            cyc_d = 1'b1;
            we_d  = 1'b0;
            dat_d = '0;
            case (state_q)
                RD_STAT: adr_d = 32'h380;
                RD_ND:   adr_d = 32'h384;
                RD_ACC:  adr_d = 32'h10 + {27'd0, idx_q, 2'b00};
                default: begin
                    adr_d = 32'h390;
                    we_d  = 1'b1;
                    dat_d = 32'h3;
                end
            endcase
        end
        if (ack) cyc_d = 1'b0;

        wptr_d = wptr_q + {{AW{1'b0}}, push};
        rptr_d = rptr_q + {{AW{1'b0}}, pop};
`ifdef NAMURU_DC_TIMEOUT_EN
        if (cyc_q && !m_ack_i && tmo_q == TW'(TIMEOUT - 1)) begin
            cyc_d   = 1'b0;
            state_d = IDLE;
            ovf_set = 1'b1;
            if (state_q == RD_ACC) wptr_d = wsave_q;
        end
`endif
        ovf_d = ovf_clr ? 1'b0 : (ovf_q | ovf_set);
    end

    always_ff @(posedge correlator_clk) begin
        if (correlator_rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            cyc_q   <= 1'b0;
            we_q    <= 1'b0;
            adr_q   <= '0;
            dat_q   <= '0;
            stat_q  <= '0;
            nd_q    <= 1'b0;
            seq_q   <= '0;
            acc_q   <= 1'b0;
            pend_q  <= 1'b0;
            ovf_q   <= 1'b0;
            wptr_q  <= '0;
            rptr_q  <= '0;
`ifdef NAMURU_DC_TIMEOUT_EN
            tmo_q   <= '0;
            wsave_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cyc_q   <= cyc_d;
            we_q    <= we_d;
            adr_q   <= adr_d;
            dat_q   <= dat_d;
            stat_q  <= stat_d;
            nd_q    <= nd_d;
            seq_q   <= seq_d;
            acc_q   <= accum_int;
            pend_q  <= pend_d;
            ovf_q   <= ovf_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
`ifdef NAMURU_DC_TIMEOUT_EN
            tmo_q   <= tmo_d;
            wsave_q <= wsave_d;
`endif
        end
    end

    always_ff @(posedge correlator_clk) begin
        if (push) mem[wptr_q[AW-1:0]] <= push_data;
    end

    assign m_adr_o  = adr_q;
    assign m_dat_o  = dat_q;
    assign m_we_o   = we_q;
    assign m_sel_o  = 4'hF;
    assign m_cyc_o  = cyc_q;
    assign m_stb_o  = cyc_q;
    assign rd_data  = mem[rptr_q[AW-1:0]];
    assign rd_empty = (level == '0);
    assign rd_level = level;
    assign overflow = ovf_q;
    assign irq      = (level >= (AW+1)'(7));
    assign busy     = (state_q != IDLE);
endmodule

// File: tb/tb_namuru_dump_collector.sv
// Scoreboard bench for namuru_dump_collector with a behavioural correlator slave.
module tb_namuru_dump_collector;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        accum_int = 1'b0;
    logic [31:0] m_adr_o, m_dat_o;
    logic [31:0] m_dat_i = '0;
    logic        m_we_o, m_cyc_o, m_stb_o;
    logic [3:0]  m_sel_o;
    logic        m_ack_i = 1'b0;
    logic        rd_en = 1'b0;
    logic [31:0] rd_data;
    logic        rd_empty;
    logic [5:0]  rd_level;
    logic        overflow, irq, busy;
    logic        ovf_clr = 1'b0;

    namuru_dump_collector dut (
        .correlator_clk(clk), .correlator_rst(rst), .accum_int(accum_int),
        .m_adr_o(m_adr_o), .m_dat_o(m_dat_o), .m_dat_i(m_dat_i),
        .m_we_o(m_we_o), .m_sel_o(m_sel_o), .m_cyc_o(m_cyc_o),
        .m_stb_o(m_stb_o), .m_ack_i(m_ack_i), .rd_en(rd_en),
        .rd_data(rd_data), .rd_empty(rd_empty), .rd_level(rd_level),
        .overflow(overflow), .ovf_clr(ovf_clr), .irq(irq), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    logic [31:0] exp_q[$];
    int pop_req = 0;
    int pops_done = 0;

    logic [31:0] st_val = 32'h3;
    logic [31:0] nd_val = 32'h1;
    bit          hold_en = 1'b0;
    logic [31:0] hold_adr = '0;
    int          lat_cnt = 0;
    int          wr_cnt = 0;
    logic [31:0] last_wadr = '0, last_wdat = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic tmo_fail(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: timed out", name);
    endtask

    function automatic logic [31:0] read_val(input logic [31:0] a);
        logic [31:0] v;
        v = 32'h0;
        if (a == 32'h380) v = st_val;
        else if (a == 32'h384) v = nd_val;
        else if (a >= 32'h10 && a <= 32'h24) v = {16'hBEEF, 16'h0011 + 16'((a - 32'h10) >> 2)};
        return v;
    endfunction

    // Correlator slave: reads ack on the third cycle of the strobe, writes on the first.
    always @(posedge clk) begin
        if (rst) begin
            m_ack_i <= 1'b0;
            lat_cnt <= 0;
        end else begin
            m_ack_i <= 1'b0;
            if (m_cyc_o && m_stb_o && !m_ack_i && !(hold_en && m_adr_o == hold_adr)) begin
                if (lat_cnt == (m_we_o ? 0 : 2)) begin
                    m_ack_i <= 1'b1;
                    m_dat_i <= read_val(m_adr_o);
                    lat_cnt <= 0;
                    if (m_we_o) begin
                        wr_cnt    <= wr_cnt + 1;
                        last_wadr <= m_adr_o;
                        last_wdat <= m_dat_o;
                    end
                end else begin
                    lat_cnt <= lat_cnt + 1;
                end
            end
        end
    end

    // Scoreboard monitor: pops one FIFO word per cycle while pops are requested.
    always @(negedge clk) begin
        rd_en = 1'b0;
        if (pops_done < pop_req && !rd_empty) begin
            if (exp_q.size() == 0) begin
                check("fifo_unexpected", rd_data, 32'hxxxxxxxx);
            end else begin
                check("fifo_word", rd_data, exp_q.pop_front());
            end
            rd_en = 1'b1;
            pops_done++;
        end
    end

    always @(negedge clk) begin
        if (!rst && dut.push && dut.level == 6'd32) begin
            n_bad++;
            $display("FAIL fifo_full_push: level %0d", rd_level);
        end
        if (rd_level > 6'd32) begin
            n_bad++;
            $display("FAIL level_range: got %0d want <=32", rd_level);
        end
    end

    task automatic push_rec(input logic [15:0] seq, input logic [1:0] st);
        exp_q.push_back({8'hA5, seq, 5'd0, 1'b1, st});
        for (int k = 0; k < 6; k++) exp_q.push_back(32'h11 + 32'(k));
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 300) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 300) tmo_fail("wait_idle");
    endtask

    task automatic wait_wr(input int target);
        int n;
        n = 0;
        while (wr_cnt < target && n < 400) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 400) tmo_fail("wait_clear_write");
    endtask

    task automatic wait_cyc_adr(input logic [31:0] a);
        int n;
        n = 0;
        while (!(m_cyc_o && m_adr_o == a) && n < 300) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 300) tmo_fail("wait_bus_adr");
    endtask

    task automatic drain(input int cnt);
        int n;
        n = 0;
        pop_req += cnt;
        while (pops_done < pop_req && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 200) tmo_fail("drain");
    endtask

    task automatic collect(input logic [31:0] st, input logic [31:0] nd);
        int w0;
        st_val = st;
        nd_val = nd;
        w0 = wr_cnt;
        @(negedge clk);
        accum_int = 1'b1;
        wait_wr(w0 + 1);
        @(negedge clk);
        accum_int = 1'b0;
        wait_idle();
        check("clr_adr", last_wadr, 32'h390);
        check("clr_dat", last_wdat, 32'h3);
    endtask

    initial begin
        int w0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_cyc", {31'd0, m_cyc_o}, 32'd0);
        check("rst_stb_we", {30'd0, m_stb_o, m_we_o}, 32'd0);
        check("rst_adr", m_adr_o, 32'd0);
        check("rst_empty", {31'd0, rd_empty}, 32'd1);
        check("rst_flags", {29'd0, overflow, irq, busy}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Single full dump.
        push_rec(16'd0, 2'd3);
        collect(32'h3, 32'h1);
        check("t1_level", 32'(rd_level), 32'd7);
        check("t1_irq", {31'd0, irq}, 32'd1);
        check("t1_sel", {28'd0, m_sel_o}, 32'hF);
        drain(7);
        check("t1_empty", {31'd0, rd_empty}, 32'd1);

        // No new data: clear only.
        w0 = wr_cnt;
        collect(32'h3, 32'h0);
        check("t2_wr", 32'(wr_cnt - w0), 32'd1);
        check("t2_level", 32'(rd_level), 32'd0);
        check("t2_busy", {31'd0, busy}, 32'd0);

        // Fill to 26 words, then a record that cannot fit.
        for (int r = 1; r <= 4; r++) begin
            push_rec(16'(r), 2'd1);
            collect(32'h1, 32'h1);
        end
        check("t3_full28", 32'(rd_level), 32'd28);
        drain(2);
        check("t3_lvl26", 32'(rd_level), 32'd26);
        collect(32'h3, 32'h1);
        check("t3_lvl_kept", 32'(rd_level), 32'd26);
        check("t3_ovf", {31'd0, overflow}, 32'd1);
        @(negedge clk);
        ovf_clr = 1'b1;
        @(negedge clk);
        ovf_clr = 1'b0;
        check("t3_ovf_clr", {31'd0, overflow}, 32'd0);
        drain(26);
        check("t3_empty", {31'd0, rd_empty}, 32'd1);

        // Second edge during accumulator reads gives exactly one extra record.
        push_rec(16'd5, 2'd3);
        push_rec(16'd6, 2'd3);
        st_val = 32'h3;
        nd_val = 32'h1;
        w0 = wr_cnt;
        @(negedge clk);
        accum_int = 1'b1;
        wait_cyc_adr(32'h14);
        @(negedge clk);
        accum_int = 1'b0;
        @(negedge clk);
        accum_int = 1'b1;
        wait_wr(w0 + 2);
        wait_idle();
        repeat (10) @(negedge clk);
        check("t4_wr", 32'(wr_cnt - w0), 32'd2);
        check("t4_level", 32'(rd_level), 32'd14);
        accum_int = 1'b0;
        drain(14);

        // Reset in the middle of the accumulator reads.
        @(negedge clk);
        accum_int = 1'b1;
        wait_cyc_adr(32'h18);
        @(negedge clk);
        rst = 1'b1;
        accum_int = 1'b0;
        @(posedge clk);
        #1;
        check("t5_cyc", {31'd0, m_cyc_o}, 32'd0);
        check("t5_empty", {31'd0, rd_empty}, 32'd1);
        @(negedge clk);
        rst = 1'b0;
        push_rec(16'd0, 2'd3);
        collect(32'h3, 32'h1);
        drain(7);

`ifdef NAMURU_DC_TIMEOUT_EN
        begin
            int hi;
            hold_adr = 32'h18;
            hold_en = 1'b1;
            @(negedge clk);
            accum_int = 1'b1;
            wait_cyc_adr(32'h18);
            hi = 1;
            while (m_cyc_o && hi < 100) begin
                @(posedge clk);
                #1;
                if (m_cyc_o) hi++;
            end
            check("t6_cyc_len", 32'(hi), 32'd15);
            @(negedge clk);
            accum_int = 1'b0;
            hold_en = 1'b0;
            wait_idle();
            check("t6_level", 32'(rd_level), 32'd0);
            check("t6_ovf", {31'd0, overflow}, 32'd1);
        end
`endif

        repeat (4) @(negedge clk);
        check("sb_left", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
